// File: rtl/sram_set_pkg.sv
// Shared definitions for the banked SRAM set controller.
//   state_t   : controller FSM states (zero-fill sweep, normal operation)
//   idx_width : width of an index able to address n items (at least 1 bit)
package sram_set_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_bank_1rw.sv
// Single-port SRAM bank model, one access per cycle.
// Ports:
//   clk : clock, rising edge
//   A   : word address
//   D   : write data
//   CEB : chip enable, active-low
//   WEB : write enable, active-low (high with CEB low = read)
//   Q   : registered read data, updated only by reads, holds otherwise
module sram_bank_1rw
    import sram_set_pkg::*;
#(
    parameter int N = 200,
    parameter int W = 160
) (
    input  logic                    clk,
    input  logic [idx_width(N)-1:0] A,
    input  logic [W-1:0]            D,
    input  logic                    CEB,
    input  logic                    WEB,
    output logic [W-1:0]            Q
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (!CEB) begin
            if (!WEB) begin
                mem[A] <= D;
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/sram_bank_set_ctrl.sv
// Controller for SET_NUM single-port SRAM banks shared between a per-bank
// compute read port and a single load port (read/write/broadcast write).
// After reset the banks can be zero-filled by a DEPTH_SRAM-cycle sweep.
// Ports:
//   clk, reset                      : clock and synchronous active-high reset
//   ld_valid_i / ld_ready_o         : load request handshake
//   ld_write_i, ld_broadcast_i      : write select, broadcast write to all banks
//   ld_set_i, ld_address_i          : target bank and word address
//   ld_write_data_i                 : load write data
//   ld_read_data_o, ld_read_valid_o : load readback data and one-cycle strobe
//   cp_enable_i, cp_address_i       : per-bank compute read enables and addresses
//   cp_read_data_o, cp_read_valid_o : per-bank compute read data and strobes
//   busy_o                          : zero-fill sweep in progress
//   addr_error_o                    : sticky out-of-range access flag
module sram_bank_set_ctrl
    import sram_set_pkg::*;
#(
    parameter int BIT_WIDTH_SRAM    = 160,
    parameter int DEPTH_SRAM        = 200,
    parameter int BIT_WIDTH_ADDRESS = 8,
    parameter int SET_NUM           = 10,
    parameter int CLEAR_ON_RESET    = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ld_valid_i,
    output logic                                   ld_ready_o,
    input  logic                                   ld_write_i,
    input  logic                                   ld_broadcast_i,
    input  logic [idx_width(SET_NUM)-1:0]          ld_set_i,
    input  logic [BIT_WIDTH_ADDRESS-1:0]           ld_address_i,
    input  logic [BIT_WIDTH_SRAM-1:0]              ld_write_data_i,
    output logic [BIT_WIDTH_SRAM-1:0]              ld_read_data_o,
    output logic                                   ld_read_valid_o,
    input  logic [SET_NUM-1:0]                     cp_enable_i,
    input  logic [BIT_WIDTH_ADDRESS*SET_NUM-1:0]   cp_address_i,
    output logic [BIT_WIDTH_SRAM*SET_NUM-1:0]      cp_read_data_o,
    output logic [SET_NUM-1:0]                     cp_read_valid_o,
    output logic                                   busy_o,
    output logic                                   addr_error_o
);

    localparam int W   = BIT_WIDTH_SRAM;
    localparam int AW  = BIT_WIDTH_ADDRESS;
    localparam int SW  = idx_width(SET_NUM);
    localparam int BAW = idx_width(DEPTH_SRAM);

    // One extra bit so DEPTH_SRAM == 2**AW does not wrap to zero.
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH_SRAM);
    localparam logic [SW:0]   SET_LIM   = (SW+1)'(SET_NUM);
    localparam logic [AW-1:0] CLR_LAST  = AW'(DEPTH_SRAM - 1);

    if (DEPTH_SRAM > 2**BIT_WIDTH_ADDRESS) begin : g_depth_check
        $error("DEPTH_SRAM does not fit in BIT_WIDTH_ADDRESS bits");
    end

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt;

    logic [BAW-1:0]  bank_a   [SET_NUM];
    logic [W-1:0]    bank_d   [SET_NUM];
    logic            bank_ceb [SET_NUM];
    logic            bank_web [SET_NUM];
    logic [W-1:0]    bank_q   [SET_NUM];

    logic [SET_NUM-1:0] cp_issue;
    logic               ld_rd_issue;
    logic               acc_err;
    logic               ld_bank_busy;
    logic               ld_set_ok;
    logic               ld_addr_ok;
    logic               ld_bcast_wr;

    logic [SET_NUM-1:0] cp_vld_p1;
    logic               ld_vld_p1;
    logic [SW-1:0]      ld_set_p1;
    logic               err_p1;
    logic [W-1:0]       cp_hold_p1 [SET_NUM];
    logic [W-1:0]       ld_hold_p1;
    logic [W-1:0]       ld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    assign ld_set_ok   = {1'b0, ld_set_i} < SET_LIM;
    assign ld_addr_ok  = addr_ok(ld_address_i);
    assign ld_bcast_wr = ld_write_i & ld_broadcast_i;

    always_comb begin
        state_next   = state;
        busy_o       = (state == ST_CLEAR);
        ld_ready_o   = 1'b0;
        cp_issue     = '0;
        ld_rd_issue  = 1'b0;
        acc_err      = 1'b0;
        ld_bank_busy = 1'b0;
        for (int i = 0; i < SET_NUM; i++) begin
            bank_ceb[i] = 1'b1;
            bank_web[i] = 1'b1;
            bank_a[i]   = '0;
            bank_d[i]   = '0;
            if (ld_set_i == SW'(i) && cp_enable_i[i]) begin
                ld_bank_busy = 1'b1;
            end
        end

        case (state)
            ST_CLEAR: begin
                for (int i = 0; i < SET_NUM; i++) begin
                    bank_ceb[i] = 1'b0;
                    bank_web[i] = 1'b0;
                    bank_a[i]   = BAW'(clr_cnt);
                end
                if (clr_cnt == CLR_LAST) begin
                    state_next = ST_READY;
                end
            end

            ST_READY: begin
                // Compute lanes own their banks outright this cycle.
                for (int i = 0; i < SET_NUM; i++) begin
                    if (cp_enable_i[i]) begin
                        if (addr_ok(cp_address_i[AW*i +: AW])) begin
                            bank_ceb[i] = 1'b0;
                            bank_a[i]   = BAW'(cp_address_i[AW*i +: AW]);
                            cp_issue[i] = 1'b1;
                        end else begin
                            acc_err = 1'b1;
                        end
                    end
                end

                // A broadcast write needs every bank idle; anything else only
                // its target bank. An out-of-range set never collides, so it is
                // accepted and then flagged as an error.
                ld_ready_o = ld_bcast_wr ? (cp_enable_i == '0) : !ld_bank_busy;

                if (ld_valid_i && ld_ready_o) begin
                    if (!ld_addr_ok || (!ld_bcast_wr && !ld_set_ok)) begin
                        acc_err = 1'b1;
                    end else begin
                        for (int i = 0; i < SET_NUM; i++) begin
                            if (ld_bcast_wr || ld_set_i == SW'(i)) begin
                                bank_ceb[i] = 1'b0;
                                bank_web[i] = !ld_write_i;
                                bank_a[i]   = BAW'(ld_address_i);
                                bank_d[i]   = ld_write_data_i;
                            end
                        end
                        ld_rd_issue = !ld_write_i;
                    end
                end
            end

            default: state_next = ST_READY;
        endcase
    end

    for (genvar g = 0; g < SET_NUM; g++) begin : g_bank
        sram_bank_1rw #(
            .N(DEPTH_SRAM),
            .W(W)
        ) u_bank (
            .clk(clk),
            .A  (bank_a[g]),
            .D  (bank_d[g]),
            .CEB(bank_ceb[g]),
            .WEB(bank_web[g]),
            .Q  (bank_q[g])
        );

        // Bank Q also changes on load reads, so the compute view is held
        // separately and only refreshed by compute reads.
        assign cp_read_data_o[W*g +: W] = cp_vld_p1[g] ? bank_q[g] : cp_hold_p1[g];
    end

    // ---- stage p1: bank read data returns ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cp_vld_p1 <= '0;
            ld_vld_p1 <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            cp_vld_p1 <= cp_issue;
            ld_vld_p1 <= ld_rd_issue;
            err_p1    <= err_p1 | acc_err;
        end
    end

    always_ff @(posedge clk) begin
        ld_set_p1 <= ld_set_i;
    end

    always_comb begin
        ld_q = '0;
        for (int i = 0; i < SET_NUM; i++) begin
            if (ld_set_p1 == SW'(i)) begin
                ld_q = bank_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SET_NUM; i++) begin
                cp_hold_p1[i] <= '0;
            end
            ld_hold_p1 <= '0;
        end else begin
            for (int i = 0; i < SET_NUM; i++) begin
                if (cp_vld_p1[i]) begin
                    cp_hold_p1[i] <= bank_q[i];
                end
            end
            if (ld_vld_p1) begin
                ld_hold_p1 <= ld_q;
            end
        end
    end

    assign cp_read_valid_o = cp_vld_p1;
    assign ld_read_valid_o = ld_vld_p1;
    assign ld_read_data_o  = ld_vld_p1 ? ld_q : ld_hold_p1;
    assign addr_error_o    = err_p1;

endmodule
